// File: rtl/id_stage_fwd_pkg.sv
// Shared OpenMIPS decode constants: instruction encodings, ALU opcodes, result selects,
// and the control-field encoding used for an empty (bubble) ID/EX slot.
package id_stage_fwd_pkg;

  localparam logic [5:0] EXE_SPECIAL_INST = 6'b000000;
  localparam logic [5:0] EXE_ANDI         = 6'b001100;
  localparam logic [5:0] EXE_ORI          = 6'b001101;
  localparam logic [5:0] EXE_XORI         = 6'b001110;
  localparam logic [5:0] EXE_LUI          = 6'b001111;
  localparam logic [5:0] EXE_PREF         = 6'b110011;

  localparam logic [5:0] EXE_AND  = 6'b100100;
  localparam logic [5:0] EXE_OR   = 6'b100101;
  localparam logic [5:0] EXE_XOR  = 6'b100110;
  localparam logic [5:0] EXE_NOR  = 6'b100111;
  localparam logic [5:0] EXE_SLL  = 6'b000000;
  localparam logic [5:0] EXE_SRL  = 6'b000010;
  localparam logic [5:0] EXE_SRA  = 6'b000011;
  localparam logic [5:0] EXE_SLLV = 6'b000100;
  localparam logic [5:0] EXE_SRLV = 6'b000110;
  localparam logic [5:0] EXE_SRAV = 6'b000111;
  localparam logic [5:0] EXE_SYNC = 6'b001111;

  localparam logic [7:0] EXE_NOP_OP  = 8'b00000000;
  localparam logic [7:0] EXE_AND_OP  = 8'b00100100;
  localparam logic [7:0] EXE_OR_OP   = 8'b00100101;
  localparam logic [7:0] EXE_XOR_OP  = 8'b00100110;
  localparam logic [7:0] EXE_NOR_OP  = 8'b00100111;
  localparam logic [7:0] EXE_SLLV_OP = 8'b00000100;
  localparam logic [7:0] EXE_SRLV_OP = 8'b00000110;
  localparam logic [7:0] EXE_SRAV_OP = 8'b00000111;
  localparam logic [7:0] EXE_SLL_OP  = 8'b01111100;
  localparam logic [7:0] EXE_SRL_OP  = 8'b00000010;
  localparam logic [7:0] EXE_SRA_OP  = 8'b00000011;

  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;

  localparam logic [4:0] NOPRegAddr = 5'b00000;

  typedef struct packed {
    logic       valid;
    logic       illegal;
    logic       wreg;
    logic [4:0] wd;
    logic [2:0] alusel;
    logic [7:0] aluop;
  } ex_ctrl_t;

  localparam ex_ctrl_t BUBBLE_CTRL = '{valid: 1'b0, illegal: 1'b0, wreg: 1'b0,
                                       wd: NOPRegAddr, alusel: EXE_RES_NOP, aluop: EXE_NOP_OP};
  localparam logic [31:0] BUBBLE_PC = 32'h0000_0000;

endpackage

// File: rtl/id_stage_fwd_mux.sv
// One operand port: lowest-index forwarding hit wins, else regfile; immediate when the read is off.
// Purely combinational; o_hit0 flags a match on source 0 for load-use detection.
module fwd_operand_mux #(
  parameter int DATA_W     = 32,
  parameter int NUM_FWD    = 2,
  parameter int ZERO_GUARD = 1
) (
  input  logic                        i_rd_en,
  input  logic [4:0]                  i_addr,
  input  logic [DATA_W-1:0]           i_rf_data,
  input  logic [DATA_W-1:0]           i_imm,
  input  logic [NUM_FWD-1:0]          i_fwd_wreg,
  input  logic [5*NUM_FWD-1:0]        i_fwd_wd,
  input  logic [DATA_W*NUM_FWD-1:0]   i_fwd_wdata,
  output logic [DATA_W-1:0]           o_data,
  output logic                        o_hit0
);

  logic w_guard;
  assign w_guard = (ZERO_GUARD != 0) && (i_addr == 5'd0);

  // Walk oldest to youngest so the youngest (lowest index) match is the last write.
  always_comb begin
    o_data = i_rf_data;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (i_fwd_wreg[k] && (i_fwd_wd[5*k +: 5] == i_addr))
        o_data = i_fwd_wdata[DATA_W*k +: DATA_W];
    end
    if (w_guard)
      o_data = '0;
    if (!i_rd_en)
      o_data = i_imm;
  end

  assign o_hit0 = i_rd_en && !w_guard && i_fwd_wreg[0] && (i_fwd_wd[4:0] == i_addr);

endmodule

// File: rtl/id_stage_fwd.sv
// Decode stage with prioritised operand forwarding, load-use stall and the ID/EX register.
// One cycle from inst_i to ex_*; hold_i freezes ID/EX, flush_i/stall/invalid load a bubble.
module id_stage_fwd
  import id_stage_fwd_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int NUM_FWD    = 2,
  parameter int ZERO_GUARD = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               pc_i,
  input  logic [31:0]               inst_i,
  input  logic                      inst_valid_i,
  input  logic [DATA_W-1:0]         reg1_data_i,
  input  logic [DATA_W-1:0]         reg2_data_i,
  input  logic [NUM_FWD-1:0]        fwd_wreg_i,
  input  logic [5*NUM_FWD-1:0]      fwd_wd_i,
  input  logic [DATA_W*NUM_FWD-1:0] fwd_wdata_i,
  input  logic                      fwd0_is_load_i,
  input  logic                      hold_i,
  input  logic                      flush_i,
  output logic                      reg1_read_o,
  output logic                      reg2_read_o,
  output logic [4:0]                reg1_addr_o,
  output logic [4:0]                reg2_addr_o,
  output logic                      stall_req_o,
  output logic [31:0]               ex_pc_o,
  output logic [7:0]                ex_aluop_o,
  output logic [2:0]                ex_alusel_o,
  output logic [DATA_W-1:0]         ex_reg1_o,
  output logic [DATA_W-1:0]         ex_reg2_o,
  output logic [4:0]                ex_wd_o,
  output logic                      ex_wreg_o,
  output logic                      ex_valid_o,
  output logic                      ex_illegal_o
);

  logic [5:0]        w_op, w_fn;
  logic [4:0]        w_rs, w_rt, w_rd, w_sa;
  logic [15:0]       w_imm;
  logic [31:0]       w_lui32;
  ex_ctrl_t          w_ctrl;
  logic              w_rd1_en, w_rd2_en, w_rr;
  logic [DATA_W-1:0] w_imm1, w_imm2, w_opnd1, w_opnd2;
  logic              w_hit0_1, w_hit0_2;

  assign w_op    = inst_i[31:26];
  assign w_rs    = inst_i[25:21];
  assign w_rt    = inst_i[20:16];
  assign w_rd    = inst_i[15:11];
  assign w_sa    = inst_i[10:6];
  assign w_fn    = inst_i[5:0];
  assign w_imm   = inst_i[15:0];
  assign w_lui32 = {w_imm, 16'h0000};

  always_comb begin
    w_ctrl         = BUBBLE_CTRL;
    w_ctrl.valid   = 1'b1;
    w_ctrl.illegal = 1'b1;
    w_rd1_en       = 1'b0;
    w_rd2_en       = 1'b0;
    w_rr           = 1'b0;
    w_imm1         = '0;
    w_imm2         = '0;
    if (inst_i[31:21] == 11'd0 && (w_fn == EXE_SLL || w_fn == EXE_SRL || w_fn == EXE_SRA)) begin
      w_ctrl.illegal = 1'b0;
      w_ctrl.wreg    = 1'b1;
      w_ctrl.wd      = w_rd;
      w_ctrl.alusel  = EXE_RES_SHIFT;
      w_rd2_en       = 1'b1;
      w_imm1         = DATA_W'(w_sa);
      case (w_fn)
        EXE_SLL: w_ctrl.aluop = EXE_SLL_OP;
        EXE_SRL: w_ctrl.aluop = EXE_SRL_OP;
        default: w_ctrl.aluop = EXE_SRA_OP;
      endcase
    end else if (w_op == EXE_SPECIAL_INST && w_sa == 5'd0) begin
      case (w_fn)
        EXE_AND:  begin w_rr = 1'b1; w_ctrl.aluop = EXE_AND_OP;  w_ctrl.alusel = EXE_RES_LOGIC; end
        EXE_OR:   begin w_rr = 1'b1; w_ctrl.aluop = EXE_OR_OP;   w_ctrl.alusel = EXE_RES_LOGIC; end
        EXE_XOR:  begin w_rr = 1'b1; w_ctrl.aluop = EXE_XOR_OP;  w_ctrl.alusel = EXE_RES_LOGIC; end
        EXE_NOR:  begin w_rr = 1'b1; w_ctrl.aluop = EXE_NOR_OP;  w_ctrl.alusel = EXE_RES_LOGIC; end
        EXE_SLLV: begin w_rr = 1'b1; w_ctrl.aluop = EXE_SLLV_OP; w_ctrl.alusel = EXE_RES_SHIFT; end
        EXE_SRLV: begin w_rr = 1'b1; w_ctrl.aluop = EXE_SRLV_OP; w_ctrl.alusel = EXE_RES_SHIFT; end
        EXE_SRAV: begin w_rr = 1'b1; w_ctrl.aluop = EXE_SRAV_OP; w_ctrl.alusel = EXE_RES_SHIFT; end
        EXE_SYNC: w_ctrl.illegal = 1'b0;
        default:  ;
      endcase
      if (w_rr) begin
        w_ctrl.illegal = 1'b0;
        w_ctrl.wreg    = 1'b1;
        w_ctrl.wd      = w_rd;
        w_rd1_en       = 1'b1;
        w_rd2_en       = 1'b1;
      end
    end else begin
      case (w_op)
        EXE_ORI, EXE_ANDI, EXE_XORI: begin
          w_ctrl.illegal = 1'b0;
          w_ctrl.wreg    = 1'b1;
          w_ctrl.wd      = w_rt;
          w_ctrl.alusel  = EXE_RES_LOGIC;
          w_rd1_en       = 1'b1;
          w_imm2         = DATA_W'(w_imm);
          w_ctrl.aluop   = (w_op == EXE_ORI)  ? EXE_OR_OP :
                           (w_op == EXE_ANDI) ? EXE_AND_OP : EXE_XOR_OP;
        end
        EXE_LUI: begin
          // Operand 1 is forced to zero through the immediate path, so no read of rs.
          w_ctrl.illegal = 1'b0;
          w_ctrl.wreg    = 1'b1;
          w_ctrl.wd      = w_rt;
          w_ctrl.alusel  = EXE_RES_LOGIC;
          w_ctrl.aluop   = EXE_OR_OP;
          w_imm2         = DATA_W'($signed(w_lui32));
        end
        EXE_PREF: w_ctrl.illegal = 1'b0;
        default:  ;
      endcase
    end
  end

  assign reg1_read_o = w_rd1_en;
  assign reg2_read_o = w_rd2_en;
  assign reg1_addr_o = w_rs;
  assign reg2_addr_o = w_rt;

  fwd_operand_mux #(.DATA_W(DATA_W), .NUM_FWD(NUM_FWD), .ZERO_GUARD(ZERO_GUARD)) u_mux1 (
    .i_rd_en(w_rd1_en), .i_addr(w_rs), .i_rf_data(reg1_data_i), .i_imm(w_imm1),
    .i_fwd_wreg(fwd_wreg_i), .i_fwd_wd(fwd_wd_i), .i_fwd_wdata(fwd_wdata_i),
    .o_data(w_opnd1), .o_hit0(w_hit0_1)
  );

  fwd_operand_mux #(.DATA_W(DATA_W), .NUM_FWD(NUM_FWD), .ZERO_GUARD(ZERO_GUARD)) u_mux2 (
    .i_rd_en(w_rd2_en), .i_addr(w_rt), .i_rf_data(reg2_data_i), .i_imm(w_imm2),
    .i_fwd_wreg(fwd_wreg_i), .i_fwd_wd(fwd_wd_i), .i_fwd_wdata(fwd_wdata_i),
    .o_data(w_opnd2), .o_hit0(w_hit0_2)
  );

  assign stall_req_o = inst_valid_i && fwd0_is_load_i && (w_hit0_1 || w_hit0_2);

  ex_ctrl_t          r_ctrl;
  logic [31:0]       r_pc;
  logic [DATA_W-1:0] r_reg1, r_reg2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl <= BUBBLE_CTRL;
      r_pc   <= BUBBLE_PC;
      r_reg1 <= '0;
      r_reg2 <= '0;
    end else if (flush_i) begin
      r_ctrl <= BUBBLE_CTRL;
      r_pc   <= BUBBLE_PC;
      r_reg1 <= '0;
      r_reg2 <= '0;
    end else if (hold_i) begin
      r_ctrl <= r_ctrl;
    end else if (stall_req_o || !inst_valid_i) begin
      r_ctrl <= BUBBLE_CTRL;
      r_pc   <= BUBBLE_PC;
      r_reg1 <= '0;
      r_reg2 <= '0;
    end else begin
      r_ctrl <= w_ctrl;
      r_pc   <= pc_i;
      r_reg1 <= w_opnd1;
      r_reg2 <= w_opnd2;
    end
  end

  assign ex_pc_o      = r_pc;
  assign ex_aluop_o   = r_ctrl.aluop;
  assign ex_alusel_o  = r_ctrl.alusel;
  assign ex_reg1_o    = r_reg1;
  assign ex_reg2_o    = r_reg2;
  assign ex_wd_o      = r_ctrl.wd;
  assign ex_wreg_o    = r_ctrl.wreg;
  assign ex_valid_o   = r_ctrl.valid;
  assign ex_illegal_o = r_ctrl.illegal;

endmodule
